// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants used by fetch and decode.
package pipeline_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Fetch control FSM states.
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // Next-PC selection for the program counter.
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_ADV  = 2'd1,
    PC_LOAD = 2'd2
  } pc_sel_t;

  // IF/ID pipeline register contents, also consumed by decode.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
  } ifid_t;

  localparam ifid_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR, pc: 32'h0, pc_plus4: 32'h0};

endpackage

// File: rtl/program_counter.sv
// Program counter register with hold / wrapping step / masked redirect.
module program_counter
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  pc_sel_t     pc_sel,
  input  logic [31:0] target,
  output logic [31:0] pc
);

  localparam logic [31:0] ADDR_MASK = 32'(MEM_BYTES - 1);

  logic [31:0] pc_next;

  // Next-PC mux: stepping wraps inside memory; redirects are forced aligned and in range.
  always_comb begin
    pc_next = pc;
    case (pc_sel)
      PC_ADV:  pc_next = (pc + PC_STEP) & ADDR_MASK;
      PC_LOAD: pc_next = target & ADDR_MASK & ~32'h3;
      default: pc_next = pc;
    endcase
  end

  // PC register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: boot/run/halt control, IF/ID register and delivered-instruction counter.
// Control priority in RUN: redirect > stall > flush > normal fetch.
module instruction_fetch_unit
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 32,
  parameter logic [31:0] LAST_PC   = 32'h0000_0010
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  output logic        halted,
  output logic [15:0] fetch_count
);

  fetch_state_t state, state_next;
  pc_sel_t      pc_sel;
  logic [31:0]  pc;
  ifid_t        ifid_q, ifid_next;
  logic         ifid_load;

  program_counter #(
    .RESET_PC  (RESET_PC),
    .MEM_BYTES (MEM_BYTES)
  ) u_pc (
    .clk    (clk),
    .reset  (reset),
    .pc_sel (pc_sel),
    .target (redirect_target),
    .pc     (pc)
  );

  // Next-state, PC select and IF/ID load decisions.
  always_comb begin
    state_next = state;
    pc_sel     = PC_HOLD;
    ifid_load  = 1'b1;
    ifid_next  = IFID_BUBBLE;
    case (state)
      BOOT: begin
        state_next = RUN;
      end
      RUN: begin
        if (redirect_valid) begin
          pc_sel = PC_LOAD;
        end else if (stall) begin
          ifid_load = 1'b0;
        end else if (flush) begin
          pc_sel = PC_ADV;
        end else begin
          pc_sel    = PC_ADV;
          ifid_next = '{valid: 1'b1, instr: imem_instr, pc: pc, pc_plus4: pc + PC_STEP};
          if (pc == LAST_PC) state_next = HALT;
        end
      end
      HALT: begin
        if (redirect_valid) begin
          pc_sel     = PC_LOAD;
          state_next = RUN;
        end
      end
      default: begin
        state_next = BOOT;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BOOT;
    else        state <= state_next;
  end

  // IF/ID pipeline register; holds only while stalled in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         ifid_q <= IFID_BUBBLE;
    else if (ifid_load) ifid_q <= ifid_next;
  end

  // Saturating count of valid instructions handed to decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_count <= 16'h0;
    end else if (ifid_load && ifid_next.valid && fetch_count != 16'hFFFF) begin
      fetch_count <= fetch_count + 16'h1;
    end
  end

  assign imem_pc       = pc;
  assign ifid_valid    = ifid_q.valid;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
  assign halted        = (state == HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small combinational instruction ROM.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall, flush, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_pc, imem_instr;
  logic        ifid_valid, halted;
  logic [31:0] ifid_instr, ifid_pc, ifid_pc_plus4;
  logic [15:0] fetch_count;

  // Second instance for the wrap scenario (LAST_PC at the top word).
  logic        w_reset;
  logic        w_zero;
  logic [31:0] w_zero32;
  logic [31:0] w_imem_pc, w_imem_instr;
  logic        w_ifid_valid, w_halted;
  logic [31:0] w_ifid_instr, w_ifid_pc, w_ifid_pc_plus4;
  logic [15:0] w_fetch_count;

  logic [31:0] rom [0:7];
  int cmp_n = 0;
  int err_n = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(32), .LAST_PC(32'h10)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .imem_pc(imem_pc), .imem_instr(imem_instr),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc_plus4(ifid_pc_plus4), .halted(halted), .fetch_count(fetch_count)
  );

  instruction_fetch_unit #(.RESET_PC(32'h0), .MEM_BYTES(32), .LAST_PC(32'h1C)) dut_w (
    .clk(clk), .reset(w_reset), .stall(w_zero), .flush(w_zero),
    .redirect_valid(w_zero), .redirect_target(w_zero32),
    .imem_pc(w_imem_pc), .imem_instr(w_imem_instr),
    .ifid_valid(w_ifid_valid), .ifid_instr(w_ifid_instr), .ifid_pc(w_ifid_pc),
    .ifid_pc_plus4(w_ifid_pc_plus4), .halted(w_halted), .fetch_count(w_fetch_count)
  );

  assign imem_instr   = rom[imem_pc[4:2]];
  assign w_imem_instr = rom[w_imem_pc[4:2]];

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0; stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b0; redirect_target = 32'h0;
    tick();
    tick();
  endtask

  // Release reset, pass BOOT and load @0 and @4 into IF/ID.
  task automatic run_to_at4();
    reset = 1'b1;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    cmp_n++; if (imem_pc !== 32'h0)     begin err_n++; $display("FAIL reset_imem_pc got %h exp %h", imem_pc, 32'h0); end
    cmp_n++; if (ifid_valid !== 1'b0)   begin err_n++; $display("FAIL reset_valid got %b exp 0", ifid_valid); end
    cmp_n++; if (ifid_instr !== 32'h0)  begin err_n++; $display("FAIL reset_instr got %h exp 0", ifid_instr); end
    cmp_n++; if (ifid_pc !== 32'h0)     begin err_n++; $display("FAIL reset_pc got %h exp 0", ifid_pc); end
    cmp_n++; if (ifid_pc_plus4 !== 32'h0) begin err_n++; $display("FAIL reset_pc_plus4 got %h exp 0", ifid_pc_plus4); end
    cmp_n++; if (halted !== 1'b0)       begin err_n++; $display("FAIL reset_halted got %b exp 0", halted); end
    cmp_n++; if (fetch_count !== 16'h0) begin err_n++; $display("FAIL reset_count got %0d exp 0", fetch_count); end
  endtask

  // Full program run, halt behaviour, then resume from HALT via redirect to 0.
  task automatic test_run_program();
    logic [31:0] exp_instr [0:4];
    exp_instr[0] = 32'h8C41000A; exp_instr[1] = 32'hAC610005; exp_instr[2] = 32'h00A31025;
    exp_instr[3] = 32'h00C70825; exp_instr[4] = 32'h3061000A;
    do_reset();
    reset = 1'b1;
    tick();
    cmp_n++; if (ifid_valid !== 1'b0 || imem_pc !== 32'h0)
      begin err_n++; $display("FAIL boot_cycle got valid=%b pc=%h exp valid=0 pc=0", ifid_valid, imem_pc); end
    for (int i = 0; i < 5; i++) begin
      tick();
      cmp_n++;
      if (ifid_valid !== 1'b1 || ifid_instr !== exp_instr[i] || ifid_pc !== 32'(4 * i) || ifid_pc_plus4 !== 32'(4 * i + 4))
        begin err_n++; $display("FAIL run_word%0d got v=%b %h@%h +4=%h exp v=1 %h@%h +4=%h", i,
          ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, exp_instr[i], 32'(4 * i), 32'(4 * i + 4)); end
    end
    cmp_n++; if (halted !== 1'b1)       begin err_n++; $display("FAIL run_halted got %b exp 1", halted); end
    cmp_n++; if (fetch_count !== 16'd5) begin err_n++; $display("FAIL run_count got %0d exp 5", fetch_count); end
    // In HALT, stall and flush are ignored and bubbles keep loading.
    stall = 1'b1; flush = 1'b1;
    tick();
    cmp_n++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || halted !== 1'b1 || imem_pc !== 32'h14)
      begin err_n++; $display("FAIL halt_bubble got v=%b instr=%h halted=%b pc=%h exp v=0 instr=0 halted=1 pc=14",
        ifid_valid, ifid_instr, halted, imem_pc); end
    stall = 1'b0; flush = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h0;
    tick();
    redirect_valid = 1'b0;
    cmp_n++; if (halted !== 1'b0 || ifid_valid !== 1'b0 || imem_pc !== 32'h0)
      begin err_n++; $display("FAIL resume_edge1 got halted=%b v=%b pc=%h exp 0 0 0", halted, ifid_valid, imem_pc); end
    tick();
    cmp_n++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8C41000A || ifid_pc !== 32'h0 || fetch_count !== 16'd6)
      begin err_n++; $display("FAIL resume_edge2 got v=%b %h@%h cnt=%0d exp v=1 8c41000a@0 cnt=6",
        ifid_valid, ifid_instr, ifid_pc, fetch_count); end
  endtask

  task automatic test_stall();
    do_reset();
    run_to_at4();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      cmp_n++;
      if (ifid_valid !== 1'b1 || ifid_instr !== 32'hAC610005 || ifid_pc !== 32'h4 || imem_pc !== 32'h8 || fetch_count !== 16'd2)
        begin err_n++; $display("FAIL stall_hold%0d got v=%b %h@%h pc=%h cnt=%0d exp v=1 ac610005@4 pc=8 cnt=2",
          k, ifid_valid, ifid_instr, ifid_pc, imem_pc, fetch_count); end
    end
    stall = 1'b0;
    tick();
    cmp_n++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h00A31025 || ifid_pc !== 32'h8 || fetch_count !== 16'd3)
      begin err_n++; $display("FAIL stall_release got v=%b %h@%h cnt=%0d exp v=1 00a31025@8 cnt=3",
        ifid_valid, ifid_instr, ifid_pc, fetch_count); end
  endtask

  task automatic test_flush();
    do_reset();
    reset = 1'b1;
    tick();
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    cmp_n++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem_pc !== 32'h8)
      begin err_n++; $display("FAIL flush_bubble got v=%b instr=%h pc=%h exp v=0 instr=0 pc=8", ifid_valid, ifid_instr, imem_pc); end
    tick();
    cmp_n++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h00A31025 || ifid_pc !== 32'h8)
      begin err_n++; $display("FAIL flush_next got v=%b %h@%h exp v=1 00a31025@8", ifid_valid, ifid_instr, ifid_pc); end
  endtask

  task automatic test_redirect();
    do_reset();
    run_to_at4();
    redirect_valid = 1'b1; redirect_target = 32'h0000_000D;
    tick();
    redirect_valid = 1'b0;
    cmp_n++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || imem_pc !== 32'hC)
      begin err_n++; $display("FAIL redirect_bubble got v=%b instr=%h pc=%h exp v=0 instr=0 pc=c", ifid_valid, ifid_instr, imem_pc); end
    tick();
    cmp_n++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h00C70825 || ifid_pc !== 32'hC || ifid_pc_plus4 !== 32'h10)
      begin err_n++; $display("FAIL redirect_target got v=%b %h@%h +4=%h exp v=1 00c70825@c +4=10",
        ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4); end
  endtask

  // Redirect beats a simultaneous stall; the out-of-range target masks down to 0x10.
  task automatic test_redirect_stall();
    do_reset();
    run_to_at4();
    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFF2; stall = 1'b1;
    tick();
    redirect_valid = 1'b0; stall = 1'b0;
    cmp_n++; if (imem_pc !== 32'h10 || ifid_valid !== 1'b0)
      begin err_n++; $display("FAIL redir_stall_pc got pc=%h v=%b exp pc=10 v=0", imem_pc, ifid_valid); end
    tick();
    cmp_n++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h3061000A || ifid_pc !== 32'h10 || halted !== 1'b1)
      begin err_n++; $display("FAIL redir_stall_load got v=%b %h@%h halted=%b exp v=1 3061000a@10 halted=1",
        ifid_valid, ifid_instr, ifid_pc, halted); end
  endtask

  // Reset asserted between clock edges while a redirect and stall are pending.
  task automatic test_async_reset();
    do_reset();
    run_to_at4();
    redirect_valid = 1'b1; redirect_target = 32'h8; stall = 1'b1;
    #2 reset = 1'b0;
    #1;
    cmp_n++;
    if (imem_pc !== 32'h0 || ifid_valid !== 1'b0 || ifid_instr !== 32'h0 || ifid_pc !== 32'h0 ||
        ifid_pc_plus4 !== 32'h0 || halted !== 1'b0 || fetch_count !== 16'h0)
      begin err_n++; $display("FAIL async_reset got pc=%h v=%b %h@%h +4=%h h=%b cnt=%0d exp all 0",
        imem_pc, ifid_valid, ifid_instr, ifid_pc, ifid_pc_plus4, halted, fetch_count); end
    redirect_valid = 1'b0; stall = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    tick();
    cmp_n++; if (ifid_valid !== 1'b0 || imem_pc !== 32'h0 || fetch_count !== 16'h0)
      begin err_n++; $display("FAIL async_reboot got v=%b pc=%h cnt=%0d exp 0 0 0", ifid_valid, imem_pc, fetch_count); end
    tick();
    cmp_n++; if (ifid_valid !== 1'b1 || ifid_instr !== 32'h8C41000A || fetch_count !== 16'd1)
      begin err_n++; $display("FAIL async_first got v=%b instr=%h cnt=%0d exp 1 8c41000a 1", ifid_valid, ifid_instr, fetch_count); end
  endtask

  // Last word at top of memory: PC wraps 28 -> 0 while the link value stays 32.
  task automatic test_wrap();
    w_reset = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      tick();
      cmp_n++;
      if (w_ifid_valid !== 1'b1 || w_ifid_instr !== rom[i] || w_ifid_pc !== 32'(4 * i) || w_ifid_pc_plus4 !== 32'(4 * i + 4))
        begin err_n++; $display("FAIL wrap_word%0d got v=%b %h@%h +4=%h exp v=1 %h@%h +4=%h", i,
          w_ifid_valid, w_ifid_instr, w_ifid_pc, w_ifid_pc_plus4, rom[i], 32'(4 * i), 32'(4 * i + 4)); end
    end
    cmp_n++; if (w_imem_pc !== 32'h0 || w_ifid_pc_plus4 !== 32'd32 || w_halted !== 1'b1 || w_fetch_count !== 16'd8)
      begin err_n++; $display("FAIL wrap_end got pc=%h +4=%h halted=%b cnt=%0d exp pc=0 +4=20 halted=1 cnt=8",
        w_imem_pc, w_ifid_pc_plus4, w_halted, w_fetch_count); end
  endtask

  initial begin
    rom[0] = 32'h8C41000A; rom[1] = 32'hAC610005; rom[2] = 32'h00A31025; rom[3] = 32'h00C70825;
    rom[4] = 32'h3061000A; rom[5] = 32'h11111111; rom[6] = 32'h22222222; rom[7] = 32'h33333333;
    w_zero = 1'b0; w_zero32 = 32'h0; w_reset = 1'b0;
    test_reset();
    test_run_program();
    test_stall();
    test_flush();
    test_redirect();
    test_redirect_stall();
    test_async_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
